report_collector: RTL and testbench
===================================

REPORT_COLLECTOR -- requirements
Module: report_collector

Interface
REQ-001 SHALL have parameter NUM_REPORTS, default 4, meaning the width of the automaton report vector.
REQ-002 SHALL have parameter TS_W, default 16, meaning the symbol-timestamp width.
REQ-003 SHALL have parameter DEPTH, default 8 (power of two, >=2), meaning the record FIFO entries.
REQ-004 clk  input  1  clock; all logic is on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 run  input  1  symbol-valid strobe, the same signal that drives the automaton run input.
REQ-007 report_vec  input  NUM_REPORTS  automaton report outputs (w_out of the report STEs), bit i = report i.
REQ-008 ovf_clear  input  1  single-cycle pulse that clears overflow and drop_count.
REQ-009 rec_valid  output  1  record available.
REQ-010 rec_ready  input  1  consumer accepts the record.
REQ-011 rec_data  output  TS_W+NUM_REPORTS  record as {timestamp, mask}, with the mask in the LSBs.
REQ-012 level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-013 overflow  output  1  sticky flag: at least one record was dropped.
REQ-014 drop_count  output  8  dropped-record count; saturates at 255.

Function
REQ-015 sym_count (TS_W bits) SHALL increment by 1 in every cycle with run=1, and SHALL wrap from 2^TS_W-1 to 0.
REQ-016 Capture SHALL occur in a cycle where run=1 and cap_mask!=0; cap_mask is defined in REQ-031/032.
REQ-017 A captured record SHALL be {sym_count value before that cycle's increment, cap_mask}.
REQ-018 When run=0, no capture SHALL occur, sym_count SHALL hold, and report_vec SHALL be ignored.
REQ-019 A record captured in cycle N SHALL be visible at rec_valid/rec_data no earlier than cycle N+1, and exactly at N+1 when the FIFO was empty.
REQ-020 rec_valid SHALL equal (level!=0); the output is first-word-fall-through.
REQ-021 A pop SHALL occur when rec_valid && rec_ready.
REQ-022 rec_data SHALL remain stable while rec_valid=1 and rec_ready=0.
REQ-023 Records SHALL be delivered in capture order, with no duplication and no loss except drops under REQ-025.
REQ-024 When capture and pop occur in the same cycle, both SHALL take effect and level SHALL be unchanged, including when the FIFO is full.
REQ-025 When capture occurs while level==DEPTH with no pop: the record SHALL be dropped, overflow SHALL be set to 1, and drop_count SHALL increment (saturating at 255).
REQ-026 ovf_clear=1 SHALL set overflow=0 and drop_count=0.
REQ-027 When ovf_clear=1 and a drop occur in the same cycle, the result SHALL be overflow=1 and drop_count=1.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 level SHALL range over 0..DEPTH inclusive.

Reset
REQ-030 While reset=1: sym_count=0, FIFO emptied (level=0, rec_valid=0), rec_data=0, overflow=0, drop_count=0, prev_vec=0, and no capture or pop takes effect.
REQ-030a Reset asserted in the middle of a stream or in the middle of a handshake SHALL discard all pending records.

Configuration
REQ-031 With macro REPORT_COLLECTOR_EDGE_EN defined: cap_mask = report_vec & ~prev_vec.
REQ-031a prev_vec SHALL register report_vec on each run=1 cycle and hold otherwise, so a report held high produces one record at its rising edge.
REQ-032 With REPORT_COLLECTOR_EDGE_EN undefined: cap_mask = report_vec, so every run cycle with any report high produces a record, and prev_vec SHALL be absent.

Verification
REQ-033 Level mode: reset, then run=1 for 5 cycles with report_vec=0,0,4'b0010,4'b1010,0 and rec_ready=1 -> exactly two records: {2,4'b0010} then {3,4'b1010}, each appearing one cycle after capture.
REQ-034 Edge mode (REPORT_COLLECTOR_EDGE_EN): report_vec=4'b0001 held for 4 run cycles starting at sym_count 0 -> exactly one record {0,4'b0001}.
REQ-034a Edge mode continued: the bit then goes to 0 for one run cycle and back to 1 -> one further record with timestamp 5.
REQ-035 Backpressure: DEPTH=8, rec_ready=0, 10 capturing run cycles -> level=8, overflow=1, drop_count=2, and rec_data holds the first record throughout.
REQ-035a Backpressure continued: the 8 drained records have timestamps 0..7.
REQ-036 Full FIFO with simultaneous capture and pop -> level stays 8, drop_count unchanged, and the new record becomes the last delivered.
REQ-036a ovf_clear asserted in the same cycle as a drop -> overflow=1, drop_count=1.
REQ-037 Wrap: TS_W=4, 17 capturing run cycles -> record timestamps 0..15 then 0.
REQ-037a Wrap continued: assert reset mid-stream with 3 records pending -> rec_valid=0 and level=0 the next cycle, and the next record carries timestamp 0.

Source files
------------

// File: rtl/report_collector_if.sv
// Record handshake bundle between the report collector and its consumer.
// DATA_W carries {timestamp, report mask}.
interface report_collector_if #(
  parameter int DATA_W = 20
) ();
  logic              rec_valid;
  logic              rec_ready;
  logic [DATA_W-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/report_collector.sv
// Timestamps automaton report vectors into a first-word-fall-through record FIFO.
// Define REPORT_COLLECTOR_EDGE_EN to record only rising report edges instead of every high cycle.
module report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int TS_W        = 16,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [NUM_REPORTS-1:0]   report_vec,
  input  logic                     ovf_clear,
  report_collector_if.master       rec,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = TS_W + NUM_REPORTS;

  logic [DW-1:0]          r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_level;
  logic [TS_W-1:0]        r_sym_count;
  logic                   r_overflow;
  logic [7:0]             r_drop_count;

  logic [NUM_REPORTS-1:0] w_cap_mask;
  logic                   w_cap;
  logic                   w_valid;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_push;
  logic                   w_drop;

`ifdef REPORT_COLLECTOR_EDGE_EN
  logic [NUM_REPORTS-1:0] r_prev_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_vec <= '0;
    end else if (run) begin
      r_prev_vec <= report_vec;
    end
  end

  assign w_cap_mask = report_vec & ~r_prev_vec;
`else
  assign w_cap_mask = report_vec;
`endif

  assign w_cap   = run && (|w_cap_mask);
  assign w_valid = (r_level != '0);
  assign w_pop   = w_valid && rec.rec_ready;
  assign w_full  = (r_level == (AW+1)'(DEPTH));
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a capture then.
  assign w_push  = w_cap && (!w_full || w_pop);
  assign w_drop  = w_cap && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= {r_sym_count, w_cap_mask};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_sym_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - (AW+1)'(1);
      end
      if (run) begin
        r_sym_count <= r_sym_count + TS_W'(1);
      end
    end
  end

  // A drop in the clearing cycle wins, leaving a count of one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clear) begin
        r_overflow <= 1'b0;
      end
      if (ovf_clear) begin
        r_drop_count <= {7'd0, w_drop};
      end else if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign rec.rec_valid = w_valid;
  assign rec.rec_data  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign level         = r_level;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;
endmodule

// File: tb/tb_report_collector.sv
// Scoreboard bench for report_collector: a 16-bit-timestamp instance and a 4-bit-timestamp
// instance share all stimulus; expected records are queued at capture and compared at pop.
module tb_report_collector;
  localparam int NR = 4;
  localparam int D  = 8;

  logic       clk;
  logic       reset;
  logic       run;
  logic [3:0] report_vec;
  logic       ovf_clear;
  logic       rdy;

  logic [3:0] level, level_w;
  logic       overflow, overflow_w;
  logic [7:0] drop_count, drop_count_w;

  report_collector_if #(.DATA_W(20)) ifc ();
  report_collector_if #(.DATA_W(8))  ifc_w ();
  assign ifc.rec_ready   = rdy;
  assign ifc_w.rec_ready = rdy;

  report_collector #(.NUM_REPORTS(NR), .TS_W(16), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .run(run), .report_vec(report_vec), .ovf_clear(ovf_clear),
    .rec(ifc), .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  report_collector #(.NUM_REPORTS(NR), .TS_W(4), .DEPTH(D)) dut_w (
    .clk(clk), .reset(reset), .run(run), .report_vec(report_vec), .ovf_clear(ovf_clear),
    .rec(ifc_w), .level(level_w), .overflow(overflow_w), .drop_count(drop_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;

  logic [19:0] m_q [$];
  logic [15:0] m_sym;
  logic [3:0]  m_prev;
  logic        m_ovf;
  logic [7:0]  m_drop;

  logic        op, ep;
  logic [19:0] od, ed;
  logic [7:0]  odw;

  // Drives one cycle from a negedge, samples the record port mid-cycle, advances the model.
  task automatic drive_cycle(input logic i_run, input logic [3:0] i_vec, input logic i_rdy,
                             input logic i_clr, input logic i_rst);
    logic [3:0] mask;
    logic       full;
    logic       drop;
    run = i_run; report_vec = i_vec; rdy = i_rdy; ovf_clear = i_clr; reset = i_rst;
    #1;
    op  = ifc.rec_valid && i_rdy && !i_rst;
    od  = ifc.rec_data;
    odw = ifc_w.rec_data;
    ep = 1'b0; ed = '0; drop = 1'b0;
    if (i_rst) begin
      m_q.delete();
      m_sym = '0; m_prev = '0; m_ovf = 1'b0; m_drop = '0;
    end else begin
      mask = i_vec;
`ifdef REPORT_COLLECTOR_EDGE_EN
      mask = i_vec & ~m_prev;
`endif
      full = (m_q.size() == D);
      if (m_q.size() != 0 && i_rdy) begin
        ep = 1'b1;
        ed = m_q.pop_front();
      end
      if (i_run && mask != 4'd0) begin
        if (!full || ep) m_q.push_back({m_sym, mask});
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (i_clr) m_ovf = 1'b0;
      if (i_clr) m_drop = drop ? 8'd1 : 8'd0;
      else if (drop && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      if (i_run) begin
        m_sym  = m_sym + 16'd1;
        m_prev = i_vec;
      end
    end
    if (op) $display("pop ts=%0d mask=%b wrap_ts=%0d", od[19:4], od[3:0], odw[7:4]);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (ifc.rec_valid !== 1'b0 || level !== 4'd0 || ifc.rec_data !== 20'd0 ||
        overflow !== 1'b0 || drop_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_main: got v=%b lvl=%0d d=%h ovf=%b drop=%0d required all zero",
               ifc.rec_valid, level, ifc.rec_data, overflow, drop_count);
    end
    n_cmp++;
    if (ifc_w.rec_valid !== 1'b0 || level_w !== 4'd0 || ifc_w.rec_data !== 8'd0 ||
        overflow_w !== 1'b0 || drop_count_w !== 8'd0) begin
      n_err++;
      $display("FAIL reset_wrap: got v=%b lvl=%0d d=%h ovf=%b drop=%0d required all zero",
               ifc_w.rec_valid, level_w, ifc_w.rec_data, overflow_w, drop_count_w);
    end
  endtask

  task automatic test_level_mode();
    logic [3:0]  vecs [6];
    logic [19:0] got [$];
    int          at [$];
    logic [19:0] exp0, exp1;
    vecs = '{4'd0, 4'd0, 4'b0010, 4'b1010, 4'd0, 4'd0};
    exp0 = {16'd2, 4'b0010};
`ifdef REPORT_COLLECTOR_EDGE_EN
    exp1 = {16'd3, 4'b1000};
`else
    exp1 = {16'd3, 4'b1010};
`endif
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(i < 5, vecs[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (op !== ep || (ep && (od !== ed || odw !== ed[7:0]))) begin
        n_err++;
        $display("FAIL level_pop%0d: got v=%b d=%h dw=%h required v=%b d=%h", i, op, od, odw, ep, ed);
      end
      if (op) begin got.push_back(od); at.push_back(i); end
    end
    n_cmp++;
    if (got.size() != 2) begin
      n_err++;
      $display("FAIL level_count: got %0d records required 2", got.size());
    end else begin
      n_cmp++;
      if (got[0] !== exp0 || at[0] != 3) begin
        n_err++;
        $display("FAIL level_rec0: got %h at cycle %0d required %h at cycle 3", got[0], at[0], exp0);
      end
      n_cmp++;
      if (got[1] !== exp1 || at[1] != 4) begin
        n_err++;
        $display("FAIL level_rec1: got %h at cycle %0d required %h at cycle 4", got[1], at[1], exp1);
      end
    end
  endtask

  task automatic test_run_gate();
    logic [19:0] got [$];
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(i == 3, (i < 4) ? 4'hF : 4'd0, 1'b1, 1'b0, 1'b0);
      if (op) got.push_back(od);
    end
    n_cmp++;
    if (got.size() != 1 || got[0] !== {16'd0, 4'hF}) begin
      n_err++;
      $display("FAIL run_gate: got %0d records first=%h required 1 record %h",
               got.size(), (got.size() > 0) ? got[0] : 20'd0, {16'd0, 4'hF});
    end
  endtask

`ifdef REPORT_COLLECTOR_EDGE_EN
  task automatic test_edge();
    logic [3:0]  vecs [7];
    logic [19:0] got [$];
    vecs = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd0};
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(i < 7, (i < 7) ? vecs[i] : 4'd0, 1'b1, 1'b0, 1'b0);
      if (op) got.push_back(od);
    end
    n_cmp++;
    if (got.size() != 2) begin
      n_err++;
      $display("FAIL edge_count: got %0d records required 2", got.size());
    end else begin
      n_cmp++;
      if (got[0] !== {16'd0, 4'd1} || got[1] !== {16'd5, 4'd1}) begin
        n_err++;
        $display("FAIL edge_recs: got %h %h required %h %h", got[0], got[1], {16'd0, 4'd1}, {16'd5, 4'd1});
      end
    end
  endtask
`endif

  task automatic test_backpressure(output logic [15:0] first_ts);
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, (i % 2) ? 4'hA : 4'h5, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (ifc.rec_valid !== 1'b1 || ifc.rec_data !== {16'd0, 4'h5}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%b d=%h required v=1 d=%h", i, ifc.rec_valid, ifc.rec_data, {16'd0, 4'h5});
      end
    end
    n_cmp++;
    if (level !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd2 ||
        level_w !== 4'd8 || drop_count_w !== 8'd2) begin
      n_err++;
      $display("FAIL bp_full: got lvl=%0d ovf=%b drop=%0d wlvl=%0d wdrop=%0d required 8 1 2 8 2",
               level, overflow, drop_count, level_w, drop_count_w);
    end
    // Full FIFO: capture and pop together.
    drive_cycle(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    first_ts = od[19:4];
    n_cmp++;
    if (op !== 1'b1 || od !== ed || level !== 4'd8 || drop_count !== 8'd2) begin
      n_err++;
      $display("FAIL full_simul: got pop=%b d=%h lvl=%0d drop=%0d required pop=1 d=%h lvl=8 drop=2",
               op, od, level, drop_count, ed);
    end
    drive_cycle(1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (level !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd1) begin
      n_err++;
      $display("FAIL clear_with_drop: got lvl=%0d ovf=%b drop=%0d required 8 1 1", level, overflow, drop_count);
    end
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (overflow !== m_ovf || drop_count !== m_drop || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clear_plain: got ovf=%b drop=%0d required 0 0", overflow, drop_count);
    end
  endtask

  task automatic test_drain(input logic [15:0] first_ts);
    logic [15:0] ts [$];
    ts.push_back(first_ts);
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (op !== ep || (ep && (od !== ed || odw !== ed[7:0]))) begin
        n_err++;
        $display("FAIL drain_pop%0d: got v=%b d=%h dw=%h required v=%b d=%h", i, op, od, odw, ep, ed);
      end
      if (op) ts.push_back(od[19:4]);
    end
    n_cmp++;
    if (ts.size() != 9) begin
      n_err++;
      $display("FAIL drain_count: got %0d records required 9", ts.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_cmp++;
        if (ts[i] !== ((i < 8) ? 16'(i) : 16'd10)) begin
          n_err++;
          $display("FAIL drain_ts%0d: got %0d required %0d", i, ts[i], (i < 8) ? i : 10);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] wts [$];
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      drive_cycle(1'b1, (i % 2) ? 4'hA : 4'h5, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (op !== ep || (ep && (od !== ed || odw !== ed[7:0]))) begin
        n_err++;
        $display("FAIL wrap_pop%0d: got v=%b d=%h dw=%h required v=%b d=%h", i, op, od, odw, ep, ed);
      end
      if (op) wts.push_back(odw[7:4]);
    end
    n_cmp++;
    if (wts.size() != 17) begin
      n_err++;
      $display("FAIL wrap_count: got %0d records required 17", wts.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        n_cmp++;
        if (wts[i] !== 4'(i % 16)) begin
          n_err++;
          $display("FAIL wrap_ts%0d: got %0d required %0d", i, wts[i], i % 16);
        end
      end
    end
    drive_cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (level !== 4'd3 || level_w !== 4'd3) begin
      n_err++;
      $display("FAIL wrap_pending: got lvl=%0d wlvl=%0d required 3", level, level_w);
    end
    drive_cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (ifc.rec_valid !== 1'b0 || level !== 4'd0 || ifc_w.rec_valid !== 1'b0 || level_w !== 4'd0) begin
      n_err++;
      $display("FAIL midreset: got v=%b lvl=%0d wv=%b wlvl=%0d required 0 0 0 0",
               ifc.rec_valid, level, ifc_w.rec_valid, level_w);
    end
    drive_cycle(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (op !== 1'b1 || od !== {16'd0, 4'h5} || odw !== {4'd0, 4'h5}) begin
      n_err++;
      $display("FAIL post_reset_rec: got pop=%b d=%h dw=%h required 1 %h %h", op, od, odw, {16'd0, 4'h5}, 8'h05);
    end
  endtask

  initial begin
    logic [15:0] first_ts;
    n_cmp = 0; n_err = 0;
    m_sym = '0; m_prev = '0; m_ovf = 1'b0; m_drop = '0;
    run = 1'b0; report_vec = '0; ovf_clear = 1'b0; rdy = 1'b0; reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_level_mode();
    test_run_gate();
`ifdef REPORT_COLLECTOR_EDGE_EN
    test_edge();
`endif
    test_backpressure(first_ts);
    test_drain(first_ts);
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
